// File: rtl/mci_pkg.sv
// rtl/mci_pkg.sv - shared types and encodings for the multicycle control unit
package mci_pkg;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXECUTE,
        ALU_WB,
        BRANCH,
        JUMP
    } state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J);
    endfunction

endpackage

// File: rtl/mci_ctrl_decode.sv
// rtl/mci_ctrl_decode.sv - combinational map from FSM state to datapath controls
module mci_ctrl_decode
    import mci_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Moore control word per state; FETCH commits IR and PC only when memory returns data
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mci_control_fsm.sv
// rtl/mci_control_fsm.sv - multicycle MIPS-subset control FSM with run gate and retire counter
module mci_control_fsm
    import mci_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op_code,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             busy,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             op_illegal;

    assign op_illegal = !is_legal_op(op_code);

    // State and retire counter; reset drops straight to IDLE so all controls clear at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; run is consulted only in IDLE and at an instruction boundary
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:      if (run) state_d = FETCH;
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default:      state_d = run ? FETCH : IDLE;
                endcase
            end
            MEM_ADDR:  state_d = (op_code == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WRITE: retire = mem_ready;
            EXECUTE:   state_d = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP: retire = 1'b1;
            default:   state_d = IDLE;
        endcase
        if (retire) begin
            state_d = run ? FETCH : IDLE;
        end
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    mci_ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

    assign busy        = (state_q != IDLE);
    assign illegal_op  = (state_q == DECODE) && op_illegal;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mci_control_fsm.sv
// tb/tb_mci_control_fsm.sv - scoreboard bench for the multicycle control FSM
module tb_mci_control_fsm;

    localparam logic [5:0] B_RTYPE = 6'b000000;
    localparam logic [5:0] B_LW    = 6'b100011;
    localparam logic [5:0] B_SW    = 6'b101011;
    localparam logic [5:0] B_BEQ   = 6'b000100;
    localparam logic [5:0] B_J     = 6'b000010;
    localparam logic [5:0] B_BAD   = 6'b111111;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MREAD = 4,
                   S_MWB = 5, S_MWRITE = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9, S_JUMP = 10;

    logic        clk, rst_n, run, mem_ready;
    logic [5:0]  op_code;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, busy, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_count;

    typedef struct {
        logic [17:0] ctl;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt;
    int          n_tests, n_fail;

    mci_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .op_code       (op_code),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .busy          (busy),
        .illegal_op    (illegal_op),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] obs_vec();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, busy, illegal_op};
    endfunction

    // Expected control word for a state, straight from the state/output table
    function automatic logic [17:0] mk(input int st, input bit rdy, input bit ill);
        logic pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, bz, il;
        logic [1:0] sb2, ao, ps;
        {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, bz, il} = '0;
        sb2 = 2'b00; ao = 2'b00; ps = 2'b00;
        bz = (st != S_IDLE);
        case (st)
            S_FETCH:  begin mr = 1; sb2 = 2'b01; irw = rdy; pw = rdy; end
            S_DECODE: begin sb2 = 2'b11; il = ill; end
            S_MADDR:  begin sa = 1; sb2 = 2'b10; end
            S_MREAD:  begin mr = 1; io = 1; end
            S_MWB:    begin rw = 1; m2r = 1; end
            S_MWRITE: begin mw = 1; io = 1; end
            S_EXEC:   begin sa = 1; ao = 2'b10; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            S_JUMP:   begin pw = 1; ps = 2'b10; end
            default:  ;
        endcase
        return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, sb2, ao, ps, bz, il};
    endfunction

    // One clock of stimulus: push the expectation, then pop and compare at the falling edge
    task automatic step(input string tag, input int st, input bit rdy, input bit rv,
                        input bit ill, input bit ret);
        exp_t e;
        mem_ready = rdy;
        run       = rv;
        e.ctl = mk(st, rdy, ill);
        e.cnt = exp_cnt;
        e.tag = tag;
        sb.push_back(e);
        if (ret) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, "/ctl"}, 64'(obs_vec()), 64'(e.ctl));
        check({e.tag, "/cnt"}, 64'(instr_count), 64'(e.cnt));
        check({e.tag, "/rd_wr_excl"}, 64'(mem_read & mem_write), 64'd0);
        check({e.tag, "/rw_pw_excl"}, 64'(reg_write & pc_write), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Full instruction from FETCH through retire; drop clears run from EXECUTE/after DECODE onward
    task automatic instr(input string tag, input logic [5:0] op, input int fw, input int mw,
                         input bit drop);
        bit rl;
        rl = !drop;
        op_code = op;
        for (int i = 0; i < fw; i++) step({tag, "/fetch_wait"}, S_FETCH, 0, 1, 0, 0);
        step({tag, "/fetch"}, S_FETCH, 1, 1, 0, 0);
        case (op)
            B_RTYPE: begin
                step({tag, "/decode"}, S_DECODE, 0, 1, 0, 0);
                step({tag, "/exec"}, S_EXEC, 0, rl, 0, 0);
                step({tag, "/alu_wb"}, S_ALUWB, 0, rl, 0, 1);
            end
            B_LW: begin
                step({tag, "/decode"}, S_DECODE, 0, 1, 0, 0);
                step({tag, "/maddr"}, S_MADDR, 0, rl, 0, 0);
                for (int i = 0; i < mw; i++) step({tag, "/mread_wait"}, S_MREAD, 0, rl, 0, 0);
                step({tag, "/mread"}, S_MREAD, 1, rl, 0, 0);
                step({tag, "/mem_wb"}, S_MWB, 0, rl, 0, 1);
            end
            B_SW: begin
                step({tag, "/decode"}, S_DECODE, 0, 1, 0, 0);
                step({tag, "/maddr"}, S_MADDR, 0, rl, 0, 0);
                for (int i = 0; i < mw; i++) step({tag, "/mwrite_wait"}, S_MWRITE, 0, rl, 0, 0);
                step({tag, "/mwrite"}, S_MWRITE, 1, rl, 0, 1);
            end
            B_BEQ: begin
                step({tag, "/decode"}, S_DECODE, 0, 1, 0, 0);
                step({tag, "/branch"}, S_BRANCH, 0, rl, 0, 1);
            end
            B_J: begin
                step({tag, "/decode"}, S_DECODE, 0, 1, 0, 0);
                step({tag, "/jump"}, S_JUMP, 0, rl, 0, 1);
            end
            default: step({tag, "/decode_illegal"}, S_DECODE, 0, rl, 1, 0);
        endcase
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = '0;
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        op_code   = 6'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset/ctl", 64'(obs_vec()), 64'd0);
        check("reset/cnt", 64'(instr_count), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step("idle_hold", S_IDLE, i[0], 0, 0, 0);
        step("idle_run", S_IDLE, 0, 1, 0, 0);

        instr("rtype", B_RTYPE, 0, 0, 0);
        instr("beq", B_BEQ, 0, 0, 0);
        check("cnt_after_two", 64'(instr_count), 64'd2);
        instr("lw", B_LW, 0, 2, 0);
        instr("sw", B_SW, 1, 1, 0);
        instr("j", B_J, 0, 0, 0);
        instr("illegal", B_BAD, 0, 0, 0);
        instr("rtype_drop", B_RTYPE, 0, 0, 1);
        step("idle_after_drop", S_IDLE, 1, 0, 0, 0);
        step("idle_after_drop", S_IDLE, 0, 0, 0, 0);
        check("cnt_after_six", 64'(instr_count), 64'd6);

        step("idle_rerun", S_IDLE, 0, 1, 0, 0);
        op_code = B_SW;
        step("sw_rst/fetch", S_FETCH, 1, 1, 0, 0);
        step("sw_rst/decode", S_DECODE, 0, 1, 0, 0);
        step("sw_rst/maddr", S_MADDR, 0, 1, 0, 0);
        step("sw_rst/mwrite_wait", S_MWRITE, 0, 1, 0, 0);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst/ctl", 64'(obs_vec()), 64'd0);
        check("async_rst/cnt", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1;
        check("async_rst_hold/ctl", 64'(obs_vec()), 64'd0);
        rst_n   = 1'b1;
        exp_cnt = '0;
        step("post_rst_idle", S_IDLE, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
